// File: rtl/fp_add_normalize_ctrl.sv
// Normalization controller for the single-precision adder: iterative leading-zero scan, flags for stage 4.
// Optional macro FP_NORM_CTRL_OVERLAP_EN lets a new operand be accepted in the same cycle a result is consumed.
module fp_add_normalize_ctrl #(
   parameter int MENT_WIDTH = 23,
   parameter int EXPO_WIDTH = 8,
   parameter int SCAN_STEP  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [MENT_WIDTH:0]           sum_in,
   input  logic [EXPO_WIDTH-1:0]         exponent_in,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(MENT_WIDTH):0]   normalize_position_out,
   output logic                          shift_right_out,
   output logic                          valid_bit_out,
   output logic                          zero_out,
   output logic                          underflow_out,
   output logic                          overflow_out,
   output logic                          busy_out
);

   localparam int POS_W = $clog2(MENT_WIDTH) + 1;
   localparam int LZ_W  = $clog2(SCAN_STEP + 1);
   localparam int CMP_W = POS_W + EXPO_WIDTH;
   localparam logic [LZ_W-1:0]       LZ_FULL = LZ_W'(SCAN_STEP);
   localparam logic [EXPO_WIDTH-1:0] OVF_LIM = EXPO_WIDTH'((1 << EXPO_WIDTH) - 2);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      SCAN  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t                 state;
   state_t                 next_state;
   logic [MENT_WIDTH:0]    w_reg;
   logic [EXPO_WIDTH-1:0]  e_reg;
   logic [POS_W-1:0]       pos_reg;
   logic [POS_W-1:0]       pos_nxt;
   logic                   zero_nxt;
   logic [SCAN_STEP-1:0]   window;
   logic [LZ_W-1:0]        lz;
   logic                   lz_found;
   logic                   carry;
   logic                   w_zero;
   logic                   w_norm;
   logic                   accept;
   logic                   hold_entry;
   logic                   carry_hold;

   assign carry  = w_reg[MENT_WIDTH];
   assign w_zero = (w_reg == '0);
   assign w_norm = w_reg[MENT_WIDTH-1];
   assign window = w_reg[MENT_WIDTH-1 -: SCAN_STEP];
   assign accept = in_valid & in_ready;

   // Leading zeros of the top window; an all-zero window reports SCAN_STEP.
   always_comb begin
      lz       = LZ_FULL;
      lz_found = 1'b0;
      for (int i = SCAN_STEP - 1; i >= 0; i--) begin
         if (!lz_found && window[i]) begin
            lz       = LZ_W'(SCAN_STEP - 1 - i);
            lz_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept) next_state = CHECK;
         end
         CHECK: begin
            if (carry || w_zero || w_norm) next_state = HOLD;
            else                           next_state = SCAN;
         end
         SCAN: begin
            if (lz != LZ_FULL) next_state = HOLD;
         end
         HOLD: begin
            if (out_ready) next_state = accept ? CHECK : IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
`ifdef FP_NORM_CTRL_OVERLAP_EN
      in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
`else
      in_ready = (state == IDLE);
`endif
      busy_out = (state != IDLE);
   end

   // Values the result registers take on the cycle the FSM enters HOLD.
   always_comb begin
      pos_nxt  = pos_reg;
      zero_nxt = 1'b0;
      if (state == SCAN) begin
         pos_nxt = pos_reg + POS_W'(lz);
      end else if (state == CHECK) begin
         pos_nxt  = '0;
         zero_nxt = !carry && w_zero;
      end
   end

   assign hold_entry = (state != HOLD) && (next_state == HOLD);
   assign carry_hold = (state == CHECK) && carry;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_reg                  <= '0;
         e_reg                  <= '0;
         pos_reg                <= '0;
         out_valid              <= 1'b0;
         normalize_position_out <= '0;
         shift_right_out        <= 1'b0;
         valid_bit_out          <= 1'b0;
         zero_out               <= 1'b0;
         underflow_out          <= 1'b0;
         overflow_out           <= 1'b0;
      end else begin
         if (accept) begin
            w_reg   <= sum_in;
            e_reg   <= exponent_in;
            pos_reg <= '0;
         end else if (state == SCAN) begin
            w_reg   <= w_reg << lz;
            pos_reg <= pos_nxt;
         end

         if (hold_entry) begin
            out_valid              <= 1'b1;
            normalize_position_out <= pos_nxt;
            shift_right_out        <= carry_hold;
            overflow_out           <= carry_hold && (e_reg >= OVF_LIM);
            zero_out               <= zero_nxt;
            valid_bit_out          <= !zero_nxt;
            underflow_out          <= (CMP_W'(pos_nxt) >= CMP_W'(e_reg)) && !zero_nxt;
         end else if ((state == HOLD) && out_ready) begin
            out_valid              <= 1'b0;
            normalize_position_out <= '0;
            shift_right_out        <= 1'b0;
            overflow_out           <= 1'b0;
            zero_out               <= 1'b0;
            valid_bit_out          <= 1'b0;
            underflow_out          <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fp_add_normalize_ctrl.sv
// Directed + random bench for fp_add_normalize_ctrl with a queue-based scoreboard of expected results.
module tb_fp_add_normalize_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] sum_in;
   logic [7:0]  exponent_in;
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  normalize_position_out;
   logic        shift_right_out;
   logic        valid_bit_out;
   logic        zero_out;
   logic        underflow_out;
   logic        overflow_out;
   logic        busy_out;

   typedef struct packed {
      logic [5:0] pos;
      logic       sr;
      logic       zero;
      logic       uf;
      logic       of;
      logic       vb;
      logic [7:0] lat;
   } exp_t;

   int   n_assert = 0;
   int   n_fail   = 0;
   exp_t sb[$];

   fp_add_normalize_ctrl #(.MENT_WIDTH(23), .EXPO_WIDTH(8), .SCAN_STEP(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .sum_in(sum_in), .exponent_in(exponent_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .normalize_position_out(normalize_position_out),
      .shift_right_out(shift_right_out), .valid_bit_out(valid_bit_out),
      .zero_out(zero_out), .underflow_out(underflow_out),
      .overflow_out(overflow_out), .busy_out(busy_out)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: count leading zeros below the carry directly; each full window costs one scan,
   // plus one terminating scan that finds the leading one.
   function automatic exp_t model(input logic [23:0] s, input logic [7:0] e);
      exp_t r;
      int   l;
      bit   found;
      r     = '0;
      l     = 0;
      found = 0;
      if (s[23]) begin
         r.sr  = 1'b1;
         r.of  = (e >= 8'd254);
         r.uf  = (e == 8'd0);
         r.vb  = 1'b1;
         r.lat = 8'd2;
      end else if (s == 24'd0) begin
         r.zero = 1'b1;
         r.lat  = 8'd2;
      end else begin
         for (int i = 22; i >= 0; i--) begin
            if (!found && s[i]) begin
               l     = 22 - i;
               found = 1;
            end
         end
         r.pos = 6'(l);
         r.uf  = (l >= int'(e));
         r.vb  = 1'b1;
         r.lat = (l == 0) ? 8'd2 : 8'(2 + l / 4 + 1);
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic check_result(input string tag, input exp_t x);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".pos"},       32'(normalize_position_out), 32'(x.pos));
      chk({tag, ".shift_right"}, 32'(shift_right_out), 32'(x.sr));
      chk({tag, ".zero"},      32'(zero_out), 32'(x.zero));
      chk({tag, ".underflow"}, 32'(underflow_out), 32'(x.uf));
      chk({tag, ".overflow"},  32'(overflow_out), 32'(x.of));
      chk({tag, ".valid_bit"}, 32'(valid_bit_out), 32'(x.vb));
   endtask

   // Wait (bounded) for out_valid; returns the edge index tN at which it is first sampled high.
   task automatic wait_result(output int lat);
      int cyc;
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      lat = cyc + 1;
   endtask

   task automatic do_op(input logic [23:0] s, input logic [7:0] e, input int hold, input string tag);
      exp_t x;
      int   lat;
      @(negedge clk);
      sum_in      = s;
      exponent_in = e;
      in_valid    = 1'b1;
      sb.push_back(model(s, e));
      chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      // Keep in_valid high with different data: it must be ignored outside IDLE.
      sum_in      = 24'd0;
      exponent_in = 8'hFF;
      chk({tag, ".busy"}, 32'(busy_out), 32'd1);
      wait_result(lat);
      in_valid = 1'b0;
      x = sb.pop_front();
      chk({tag, ".latency"}, 32'(lat), 32'(x.lat));
      for (int i = 0; i <= hold; i++) begin
         check_result(tag, x);
         if (i < hold) begin
            @(posedge clk); #1;
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, ".post_valid"}, 32'(out_valid), 32'd0);
      chk({tag, ".post_in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, ".post_busy"}, 32'(busy_out), 32'd0);
      chk({tag, ".post_flags"},
          32'({normalize_position_out, shift_right_out, zero_out, underflow_out, overflow_out, valid_bit_out}),
          32'd0);
   endtask

   initial begin
      rst         = 1'b1;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      sum_in      = '0;
      exponent_in = '0;
      #12;
      chk("reset.out_valid", 32'(out_valid), 32'd0);
      chk("reset.in_ready",  32'(in_ready), 32'd1);
      chk("reset.busy",      32'(busy_out), 32'd0);
      chk("reset.outputs",
          32'({normalize_position_out, shift_right_out, zero_out, underflow_out, overflow_out, valid_bit_out}),
          32'd0);
      @(negedge clk);
      rst = 1'b0;

      do_op(24'h800000, 8'h80, 0, "carry");
      do_op(24'h000001, 8'h90, 0, "deep_scan");
      do_op(24'h000000, 8'h40, 0, "zero");
      do_op(24'h000100, 8'h0A, 0, "underflow");
      do_op(24'h000100, 8'h0E, 0, "uf_equal");
      do_op(24'h000100, 8'h0F, 0, "uf_above");
      do_op(24'hC00000, 8'hFE, 0, "overflow");
      do_op(24'h800000, 8'hFD, 0, "ovf_below");
      do_op(24'h400000, 8'h05, 0, "normalized");
      do_op(24'h000004, 8'h20, 0, "scan_multiple");
      do_op(24'h000010, 8'h80, 5, "backpressure");

      // Reset while the second operand is in SCAN: result discarded, no handshake.
      @(negedge clk);
      sum_in      = 24'h000010;
      exponent_in = 8'h80;
      in_valid    = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("rst_scan.busy_before", 32'(busy_out), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst_scan.out_valid", 32'(out_valid), 32'd0);
      chk("rst_scan.in_ready",  32'(in_ready), 32'd1);
      chk("rst_scan.busy",      32'(busy_out), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      do_op(24'h000010, 8'h80, 0, "after_reset");

      for (int k = 0; k < 8; k++) begin
         logic [23:0] rs;
         rs = 24'($urandom) >> $urandom_range(0, 23);
         do_op(rs, 8'($urandom_range(0, 30)), k % 3, "random");
      end

`ifdef FP_NORM_CTRL_OVERLAP_EN
      begin
         exp_t xa;
         exp_t xb;
         int   lat;
         @(negedge clk);
         sum_in      = 24'h800000;
         exponent_in = 8'h80;
         in_valid    = 1'b1;
         out_ready   = 1'b1;
         sb.push_back(model(24'h800000, 8'h80));
         @(posedge clk); #1;
         sum_in      = 24'h000100;
         exponent_in = 8'h0A;
         sb.push_back(model(24'h000100, 8'h0A));
         wait_result(lat);
         xa = sb.pop_front();
         chk("overlap.a_latency", 32'(lat), 32'(xa.lat));
         check_result("overlap.a", xa);
         chk("overlap.in_ready_hold", 32'(in_ready), 32'd1);
         @(posedge clk); #1;
         in_valid = 1'b0;
         chk("overlap.no_bubble_busy", 32'(busy_out), 32'd1);
         chk("overlap.valid_drop", 32'(out_valid), 32'd0);
         out_ready = 1'b0;
         wait_result(lat);
         xb = sb.pop_front();
         chk("overlap.b_latency", 32'(lat), 32'(xb.lat));
         check_result("overlap.b", xb);
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
         chk("overlap.idle", 32'(busy_out), 32'd0);
      end
`endif

      chk("scoreboard.empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
